mac_row_cfg: RTL

MAC_ROW_CFG -- requirements
Module: mac_row_cfg

---
 rtl/mac_row_cfg.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mac_row_cfg.sv
// One row of a configurable systolic MAC array: per-column signed weights, WS/OS accumulate,
// a serial weight-load FSM, and a west-to-east activation/instruction pipeline.
module mac_row_cfg #(
  parameter int bw      = 2,
  parameter int b_bw    = 4,
  parameter int psum_bw = 32,
  parameter int col     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [b_bw-1:0]        in_w,
  input  logic [4:0]             inst_w,
  input  logic [psum_bw*col-1:0] in_n,
  output logic [psum_bw*col-1:0] out_s,
  output logic [col-1:0]         valid,
  output logic [b_bw-1:0]        out_e,
  output logic [4:0]             inst_e,
  output logic                   busy,
  output logic                   load_done
);

  localparam int CW = $clog2(col) + 1;
  localparam logic [b_bw-1:0] LOW_MASK = b_bw'((1 << bw) - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                   state_q;
  logic [CW-1:0]            cnt_q;
  logic                     busy_q;
  logic                     load_done_q;
  logic signed [bw-1:0]     w_q    [col];
  logic [b_bw-1:0]          act_q  [col];
  logic [4:0]               inst_q [col];
  logic [psum_bw-1:0]       acc_q  [col];
  logic [psum_bw-1:0]       out_q  [col];
  logic [col-1:0]           valid_q;
  logic signed [psum_bw-1:0] prod  [col];
  logic [4:0]               inst_gated;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      for (int unsigned c = 0; c < col; c++) w_q[c] <= '0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (inst_w[0]) begin
            w_q[0] <= in_w[bw-1:0];
            if (col > 1) begin
              state_q <= LOAD;
              cnt_q   <= CW'(1);
              busy_q  <= 1'b1;
            end else begin
              load_done_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          for (int unsigned c = 0; c < col; c++)
            if (cnt_q == CW'(c)) w_q[c] <= in_w[bw-1:0];
          if (cnt_q == CW'(col - 1)) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // West instructions are dropped while a load is running or being started.
  assign inst_gated = (busy_q || inst_w[0]) ? '0 : inst_w;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned c = 0; c < col; c++) begin
        act_q[c]  <= '0;
        inst_q[c] <= '0;
      end
    end else begin
      act_q[0]  <= in_w;
      inst_q[0] <= inst_gated;
      for (int unsigned c = 1; c < col; c++) begin
        act_q[c]  <= act_q[c-1];
        inst_q[c] <= inst_q[c-1];
      end
    end
  end

  always_comb begin
    logic [b_bw-1:0]           a;
    logic signed [psum_bw-1:0] a_ext;
    logic signed [psum_bw-1:0] w_ext;
    for (int unsigned c = 0; c < col; c++) begin
      a       = inst_q[c][2] ? act_q[c] : (act_q[c] & LOW_MASK);
      a_ext   = {{(psum_bw-b_bw){1'b0}}, a};
      w_ext   = {{(psum_bw-bw){w_q[c][bw-1]}}, w_q[c]};
      prod[c] = a_ext * w_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      for (int unsigned c = 0; c < col; c++) begin
        acc_q[c] <= '0;
        out_q[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < col; c++) begin
        valid_q[c] <= 1'b0;
        if (!inst_q[c][3]) begin
          if (inst_q[c][1]) begin
            out_q[c]   <= in_n[psum_bw*c +: psum_bw] + prod[c];
            valid_q[c] <= 1'b1;
          end
        end else if (inst_q[c][4]) begin
          out_q[c]   <= acc_q[c] + (inst_q[c][1] ? prod[c] : '0);
          acc_q[c]   <= '0;
          valid_q[c] <= 1'b1;
        end else if (inst_q[c][1]) begin
          acc_q[c] <= acc_q[c] + prod[c];
        end
      end
    end
  end

  always_comb begin
    out_s = '0;
    for (int unsigned c = 0; c < col; c++) out_s[psum_bw*c +: psum_bw] = out_q[c];
  end

  assign valid     = valid_q;
  assign out_e     = act_q[col-1];
  assign inst_e    = inst_q[col-1];
  assign busy      = busy_q;
  assign load_done = load_done_q;

endmodule
